// File: rtl/nh_lcd_bus_arbiter.sv
// nh_lcd_bus_arbiter
// Shares the single 8080-style LCD bus between the command path (requester 0,
// "cmd") and the pixel writer (requester 1, "data"). Grants are round-robin on
// ties, with an idle turnaround gap after every release. The bus pins and the
// read-back byte are registered.
//
// Parameters
//   TURNAROUND  idle cycles inserted after each release (0 = none)
//   HOLD_LIMIT  owner cycles tolerated while the other side waits before the
//               sticky overrun flag sets (0 = disabled)
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   i_enable                      gates new grants only
//   i_cmd_req / i_data_req        requests, held for the whole transaction
//   o_cmd_gnt / o_data_gnt        registered one-hot grants
//   i_*_cmd_mode, i_*_data_out, i_*_write, i_*_read, i_*_data_out_en
//                                 per-requester bus controls
//   o_cmd_mode, o_data_out, o_write, o_read, o_data_out_en
//                                 registered bus pins
//   i_data_in / o_rd_data         bus read byte, registered to both requesters
//   o_owner                       0 none, 1 cmd, 2 data
//   o_overrun, i_clear_overrun    sticky hold-limit flag and its clear
module nh_lcd_bus_arbiter #(
    parameter int TURNAROUND = 2,
    parameter int HOLD_LIMIT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_enable,
    input  logic       i_cmd_req,
    input  logic       i_data_req,
    output logic       o_cmd_gnt,
    output logic       o_data_gnt,
    input  logic       i_cmd_cmd_mode,
    input  logic       i_data_cmd_mode,
    input  logic [7:0] i_cmd_data_out,
    input  logic [7:0] i_data_data_out,
    input  logic       i_cmd_write,
    input  logic       i_data_write,
    input  logic       i_cmd_read,
    input  logic       i_data_read,
    input  logic       i_cmd_data_out_en,
    input  logic       i_data_data_out_en,
    output logic       o_cmd_mode,
    output logic       o_write,
    output logic       o_read,
    output logic       o_data_out_en,
    output logic [7:0] o_data_out,
    input  logic [7:0] i_data_in,
    output logic [7:0] o_rd_data,
    output logic [1:0] o_owner,
    output logic       o_overrun,
    input  logic       i_clear_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN_CMD,
        ST_OWN_DATA,
        ST_TURNAROUND
    } state_t;

    localparam logic [15:0] TA_LOAD = 16'(TURNAROUND - 1);
    localparam logic [15:0] HOLD_M1 = 16'(HOLD_LIMIT - 1);

    state_t      state;
    state_t      next_state;
    logic [15:0] ta_cnt;
    logic [15:0] hold_cnt;
    logic        last_owner_data;
    logic        grant;
    logic        hold_inc;
    logic        ovr_set;

    // Next-state decision. Ties in IDLE go to whoever did not own last.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (i_enable) begin
                    if (i_cmd_req && i_data_req)
                        next_state = last_owner_data ? ST_OWN_CMD : ST_OWN_DATA;
                    else if (i_cmd_req)
                        next_state = ST_OWN_CMD;
                    else if (i_data_req)
                        next_state = ST_OWN_DATA;
                end
            end
            ST_OWN_CMD: begin
                if (!i_cmd_req)
                    next_state = (TURNAROUND == 0) ? ST_IDLE : ST_TURNAROUND;
            end
            ST_OWN_DATA: begin
                if (!i_data_req)
                    next_state = (TURNAROUND == 0) ? ST_IDLE : ST_TURNAROUND;
            end
            ST_TURNAROUND: begin
                if (ta_cnt == 16'd0)
                    next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // The overrun flag sets on the cycle the hold count steps onto the limit,
    // so a clear issued while the owner keeps holding is not undone.
    always_comb begin
        grant    = (state == ST_IDLE) && (next_state != ST_IDLE);
        hold_inc = ((state == ST_OWN_CMD) && i_data_req) ||
                   ((state == ST_OWN_DATA) && i_cmd_req);
        ovr_set  = (HOLD_LIMIT != 0) && hold_inc &&
                   (hold_cnt != 16'hFFFF) && (hold_cnt == HOLD_M1);
    end

    // Arbitration state, counters, grant/owner outputs and overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            ta_cnt          <= 16'd0;
            hold_cnt        <= 16'd0;
            last_owner_data <= 1'b1;
            o_cmd_gnt       <= 1'b0;
            o_data_gnt      <= 1'b0;
            o_owner         <= 2'd0;
            o_overrun       <= 1'b0;
        end else begin
            state      <= next_state;
            o_cmd_gnt  <= (next_state == ST_OWN_CMD);
            o_data_gnt <= (next_state == ST_OWN_DATA);
            o_owner    <= (next_state == ST_OWN_CMD)  ? 2'd1 :
                          (next_state == ST_OWN_DATA) ? 2'd2 : 2'd0;

            if ((state != ST_TURNAROUND) && (next_state == ST_TURNAROUND))
                ta_cnt <= TA_LOAD;
            else if ((state == ST_TURNAROUND) && (ta_cnt != 16'd0))
                ta_cnt <= ta_cnt - 16'd1;

            if (grant) begin
                last_owner_data <= (next_state == ST_OWN_DATA);
                hold_cnt        <= 16'd0;
            end else if (hold_inc && (hold_cnt != 16'hFFFF)) begin
                hold_cnt <= hold_cnt + 16'd1;
            end

            if (ovr_set)
                o_overrun <= 1'b1;
            else if (i_clear_overrun)
                o_overrun <= 1'b0;
        end
    end

    // Bus pin register: the owner's controls pass through one cycle late;
    // otherwise the bus sits at idle levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_cmd_mode    <= 1'b1;
            o_data_out    <= 8'd0;
            o_write       <= 1'b0;
            o_read        <= 1'b0;
            o_data_out_en <= 1'b0;
            o_rd_data     <= 8'd0;
        end else begin
            o_rd_data <= i_data_in;
            case (state)
                ST_OWN_CMD: begin
                    o_cmd_mode    <= i_cmd_cmd_mode;
                    o_data_out    <= i_cmd_data_out;
                    o_write       <= i_cmd_write;
                    o_read        <= i_cmd_read;
                    o_data_out_en <= i_cmd_data_out_en;
                end
                ST_OWN_DATA: begin
                    o_cmd_mode    <= i_data_cmd_mode;
                    o_data_out    <= i_data_data_out;
                    o_write       <= i_data_write;
                    o_read        <= i_data_read;
                    o_data_out_en <= i_data_data_out_en;
                end
                default: begin
                    o_cmd_mode    <= 1'b1;
                    o_data_out    <= 8'd0;
                    o_write       <= 1'b0;
                    o_read        <= 1'b0;
                    o_data_out_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nh_lcd_bus_arbiter.sv
// tb_nh_lcd_bus_arbiter
// Directed bench for nh_lcd_bus_arbiter (TURNAROUND=2, HOLD_LIMIT=8).
// A cycle-level ownership model (owner id, "bus free at cycle N" arithmetic,
// hold count) predicts every output; one process compares it on each falling
// edge, and the directed sequence adds hand-computed literal checks.
module tb_nh_lcd_bus_arbiter;

    localparam int TURN = 2;
    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_enable;
    logic       i_cmd_req, i_data_req;
    logic       o_cmd_gnt, o_data_gnt;
    logic       i_cmd_cmd_mode, i_data_cmd_mode;
    logic [7:0] i_cmd_data_out, i_data_data_out;
    logic       i_cmd_write, i_data_write, i_cmd_read, i_data_read;
    logic       i_cmd_data_out_en, i_data_data_out_en;
    logic       o_cmd_mode, o_write, o_read, o_data_out_en;
    logic [7:0] o_data_out;
    logic [7:0] i_data_in;
    logic [7:0] o_rd_data;
    logic [1:0] o_owner;
    logic       o_overrun;
    logic       i_clear_overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nh_lcd_bus_arbiter #(.TURNAROUND(TURN), .HOLD_LIMIT(HOLD)) dut (
        .clk(clk), .rst(rst), .i_enable(i_enable),
        .i_cmd_req(i_cmd_req), .i_data_req(i_data_req),
        .o_cmd_gnt(o_cmd_gnt), .o_data_gnt(o_data_gnt),
        .i_cmd_cmd_mode(i_cmd_cmd_mode), .i_data_cmd_mode(i_data_cmd_mode),
        .i_cmd_data_out(i_cmd_data_out), .i_data_data_out(i_data_data_out),
        .i_cmd_write(i_cmd_write), .i_data_write(i_data_write),
        .i_cmd_read(i_cmd_read), .i_data_read(i_data_read),
        .i_cmd_data_out_en(i_cmd_data_out_en), .i_data_data_out_en(i_data_data_out_en),
        .o_cmd_mode(o_cmd_mode), .o_write(o_write), .o_read(o_read),
        .o_data_out_en(o_data_out_en), .o_data_out(o_data_out),
        .i_data_in(i_data_in), .o_rd_data(o_rd_data),
        .o_owner(o_owner), .o_overrun(o_overrun), .i_clear_overrun(i_clear_overrun)
    );

    // Model state: who owns the bus, when it may next be granted, last owner,
    // hold count and the expected registered pins.
    bit         m_valid = 1'b0;
    int         m_owner, m_last, m_hold, m_cyc = 0, m_free_at;
    logic       m_ovr, e_cmd_mode, e_write, e_read, e_oe;
    logic [7:0] e_dout, e_rd;

    always @(posedge clk) begin
        int  other_req, own_req;
        bit  set_ovr;
        if (rst) begin
            m_valid = 1'b1; m_owner = 0; m_last = 2; m_hold = 0; m_free_at = 0;
            m_ovr = 1'b0; e_cmd_mode = 1'b1; e_write = 1'b0; e_read = 1'b0;
            e_oe = 1'b0; e_dout = 8'd0; e_rd = 8'd0;
        end else begin
            if (m_owner == 1) begin
                e_cmd_mode = i_cmd_cmd_mode; e_dout = i_cmd_data_out;
                e_write = i_cmd_write; e_read = i_cmd_read; e_oe = i_cmd_data_out_en;
            end else if (m_owner == 2) begin
                e_cmd_mode = i_data_cmd_mode; e_dout = i_data_data_out;
                e_write = i_data_write; e_read = i_data_read; e_oe = i_data_data_out_en;
            end else begin
                e_cmd_mode = 1'b1; e_dout = 8'd0; e_write = 1'b0; e_read = 1'b0; e_oe = 1'b0;
            end
            e_rd = i_data_in;
            set_ovr = 1'b0;
            if (m_owner != 0) begin
                own_req   = (m_owner == 1) ? int'(i_cmd_req) : int'(i_data_req);
                other_req = (m_owner == 1) ? int'(i_data_req) : int'(i_cmd_req);
                if (other_req != 0 && m_hold < 65535) begin
                    m_hold++;
                    if (HOLD != 0 && m_hold == HOLD) set_ovr = 1'b1;
                end
                if (own_req == 0) begin
                    m_owner   = 0;
                    m_free_at = m_cyc + TURN + 1;
                end
            end else if (m_cyc >= m_free_at && i_enable && (i_cmd_req || i_data_req)) begin
                if (i_cmd_req && i_data_req) m_owner = (m_last == 2) ? 1 : 2;
                else                         m_owner = i_cmd_req ? 1 : 2;
                m_last = m_owner;
                m_hold = 0;
            end
            m_ovr = set_ovr ? 1'b1 : (i_clear_overrun ? 1'b0 : m_ovr);
        end
        m_cyc++;
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s at %0t: actual %h required %h", name, $time, act, req);
        end
    endtask

    // Model comparison on every falling edge once reset has been seen.
    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("cmp_cmd_gnt",  8'(o_cmd_gnt),     8'(m_owner == 1));
            checkOutput("cmp_data_gnt", 8'(o_data_gnt),    8'(m_owner == 2));
            checkOutput("cmp_owner",    8'(o_owner),       8'(m_owner));
            checkOutput("cmp_cmd_mode", 8'(o_cmd_mode),    8'(e_cmd_mode));
            checkOutput("cmp_data_out", o_data_out,        e_dout);
            checkOutput("cmp_write",    8'(o_write),       8'(e_write));
            checkOutput("cmp_read",     8'(o_read),        8'(e_read));
            checkOutput("cmp_oe",       8'(o_data_out_en), 8'(e_oe));
            checkOutput("cmp_rd_data",  o_rd_data,         e_rd);
            checkOutput("cmp_overrun",  8'(o_overrun),     8'(m_ovr));
        end
    end

    task automatic tick();
        @(negedge clk);
        i_data_in = i_data_in + 8'h35;
    endtask

    task automatic applyStimulus(input bit which, input logic req, input logic cmd_mode,
                                 input logic [7:0] dout, input logic wr, input logic rd,
                                 input logic oe);
        if (which == 1'b0) begin
            i_cmd_req = req; i_cmd_cmd_mode = cmd_mode; i_cmd_data_out = dout;
            i_cmd_write = wr; i_cmd_read = rd; i_cmd_data_out_en = oe;
        end else begin
            i_data_req = req; i_data_cmd_mode = cmd_mode; i_data_data_out = dout;
            i_data_write = wr; i_data_read = rd; i_data_data_out_en = oe;
        end
    endtask

    task automatic waitGrant(input string name, input int which, input int max_cycles);
        int n = 0;
        while (n < max_cycles && !((which == 1) ? o_cmd_gnt : o_data_gnt)) begin
            tick();
            n++;
        end
        checks++;
        if (!((which == 1) ? o_cmd_gnt : o_data_gnt)) begin
            errors++;
            $display("[TB] FAIL %s: actual no grant after %0d cycles, required grant", name, max_cycles);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual timeout, required $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; i_enable = 1'b1; i_clear_overrun = 1'b0; i_data_in = 8'h5A;
        applyStimulus(0, 0, 1, 8'h00, 0, 0, 0);
        applyStimulus(1, 0, 1, 8'h00, 0, 0, 0);
        repeat (3) tick();
        checkOutput("reset_owner",    8'(o_owner),    8'd0);
        checkOutput("reset_cmd_mode", 8'(o_cmd_mode), 8'd1);
        checkOutput("reset_rd_data",  o_rd_data,      8'd0);
        checkOutput("reset_gnt",      8'({o_cmd_gnt, o_data_gnt}), 8'd0);
        rst = 1'b0;

        $display("[TB] single cmd transaction");
        applyStimulus(0, 1, 1, 8'h00, 0, 0, 0);
        tick();
        checkOutput("t1_cmd_gnt", 8'(o_cmd_gnt), 8'd1);
        checkOutput("t1_owner",   8'(o_owner),   8'd1);
        applyStimulus(0, 1, 0, 8'h2C, 1, 0, 1);
        tick();
        checkOutput("t1_pin_data", o_data_out,          8'h2C);
        checkOutput("t1_pin_mode", 8'(o_cmd_mode),      8'd0);
        checkOutput("t1_pin_wr",   8'(o_write),         8'd1);
        tick(); tick();
        applyStimulus(0, 0, 1, 8'h00, 0, 0, 0);
        applyStimulus(1, 1, 1, 8'h00, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t1_gap_no_gnt", 8'({o_cmd_gnt, o_data_gnt}), 8'd0);
        end
        checkOutput("t1_owner_released", 8'(o_owner), 8'd0);
        tick();
        checkOutput("t1_data_gnt_after_gap", 8'(o_data_gnt), 8'd1);
        applyStimulus(1, 0, 1, 8'h00, 0, 0, 0);
        repeat (5) tick();

        $display("[TB] simultaneous requests from reset");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(0, 1, 1, 8'h00, 0, 0, 0);
        applyStimulus(1, 1, 1, 8'h00, 0, 0, 0);
        tick();
        checkOutput("t2_cmd_first",  8'(o_cmd_gnt),  8'd1);
        checkOutput("t2_data_waits", 8'(o_data_gnt), 8'd0);
        tick();
        applyStimulus(0, 0, 1, 8'h00, 0, 0, 0);
        waitGrant("t2_data_after_cmd", 2, 8);
        checkOutput("t2_owner_data", 8'(o_owner), 8'd2);
        applyStimulus(0, 1, 1, 8'h00, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 1, 8'h00, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 1, 8'h00, 0, 0, 0);
        waitGrant("t2_tie_grant", 1, 8);
        checkOutput("t2_tie_owner", 8'(o_owner),    8'd1);
        checkOutput("t2_tie_data",  8'(o_data_gnt), 8'd0);
        applyStimulus(0, 0, 1, 8'h00, 0, 0, 0);
        applyStimulus(1, 0, 1, 8'h00, 0, 0, 0);
        repeat (5) tick();

        $display("[TB] isolation");
        applyStimulus(1, 1, 1, 8'h00, 0, 0, 0);
        waitGrant("t3_data_gnt", 2, 8);
        applyStimulus(1, 1, 1, 8'hA5, 1, 0, 1);
        applyStimulus(0, 0, 0, 8'hFF, 1, 0, 1);
        tick();
        checkOutput("t3_pin_data", o_data_out,     8'hA5);
        checkOutput("t3_pin_mode", 8'(o_cmd_mode), 8'd1);
        checkOutput("t3_cmd_gnt",  8'(o_cmd_gnt),  8'd0);
        applyStimulus(0, 0, 0, 8'hFF, 0, 1, 0);
        applyStimulus(1, 1, 0, 8'h3C, 1, 0, 1);
        tick();
        checkOutput("t3_pin_data2", o_data_out,     8'h3C);
        checkOutput("t3_pin_read",  8'(o_read),     8'd0);
        checkOutput("t3_pin_mode2", 8'(o_cmd_mode), 8'd0);
        applyStimulus(1, 0, 1, 8'h00, 0, 0, 0);
        applyStimulus(0, 0, 1, 8'h00, 0, 0, 0);
        repeat (5) tick();

        $display("[TB] overrun");
        i_clear_overrun = 1'b1;
        tick();
        i_clear_overrun = 1'b0;
        applyStimulus(1, 1, 1, 8'h00, 0, 0, 0);
        waitGrant("t4_data_gnt", 2, 8);
        applyStimulus(0, 1, 1, 8'h00, 0, 0, 0);
        for (int i = 1; i < HOLD; i++) begin
            tick();
            checkOutput("t4_ovr_low", 8'(o_overrun), 8'd0);
        end
        tick();
        checkOutput("t4_ovr_set",  8'(o_overrun), 8'd1);
        checkOutput("t4_owner",    8'(o_owner),   8'd2);
        repeat (12) tick();
        checkOutput("t4_ovr_sticky", 8'(o_overrun),  8'd1);
        checkOutput("t4_not_revoked", 8'(o_data_gnt), 8'd1);
        i_clear_overrun = 1'b1;
        tick();
        i_clear_overrun = 1'b0;
        checkOutput("t4_ovr_cleared", 8'(o_overrun), 8'd0);
        tick();
        checkOutput("t4_ovr_stays_clear", 8'(o_overrun), 8'd0);
        applyStimulus(0, 0, 1, 8'h00, 0, 0, 0);
        applyStimulus(1, 0, 1, 8'h00, 0, 0, 0);
        repeat (5) tick();

        $display("[TB] enable gating");
        i_enable = 1'b0;
        applyStimulus(0, 1, 1, 8'h00, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("t5_gated", 8'(o_cmd_gnt), 8'd0);
        end
        i_enable = 1'b1;
        tick();
        checkOutput("t5_gnt_on_enable", 8'(o_cmd_gnt), 8'd1);
        i_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("t5_keeps_bus", 8'(o_owner), 8'd1);
        end
        applyStimulus(0, 0, 1, 8'h00, 0, 0, 0);
        tick();
        checkOutput("t5_released", 8'(o_cmd_gnt), 8'd0);
        i_enable = 1'b1;
        repeat (4) tick();

        $display("[TB] reset mid-frame");
        applyStimulus(1, 1, 1, 8'h00, 0, 0, 0);
        waitGrant("t6_data_gnt", 2, 8);
        applyStimulus(1, 1, 1, 8'h77, 1, 0, 1);
        tick();
        checkOutput("t6_write_high", 8'(o_write), 8'd1);
        rst = 1'b1;
        tick();
        checkOutput("t6_rst_gnt",      8'({o_cmd_gnt, o_data_gnt}), 8'd0);
        checkOutput("t6_rst_owner",    8'(o_owner),       8'd0);
        checkOutput("t6_rst_cmd_mode", 8'(o_cmd_mode),    8'd1);
        checkOutput("t6_rst_data_out", o_data_out,        8'd0);
        checkOutput("t6_rst_write",    8'(o_write),       8'd0);
        checkOutput("t6_rst_oe",       8'(o_data_out_en), 8'd0);
        checkOutput("t6_rst_rd_data",  o_rd_data,         8'd0);
        rst = 1'b0;
        applyStimulus(1, 1, 1, 8'h00, 0, 0, 0);
        tick();
        checkOutput("t6_regrant_no_gap", 8'(o_data_gnt), 8'd1);
        applyStimulus(1, 0, 1, 8'h00, 0, 0, 0);
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nh_lcd_bus_arbiter.md
# nh_lcd_bus_arbiter

Arbitrates the single 8080-style LCD physical bus between two requesters: the command/register path (requester 0, "cmd") and the pixel stream writer (requester 1, "data"). Grants exclusive ownership with round-robin fairness and inserts an idle turnaround gap between owners. Drives the registered bus pins and returns read data to the requesters. Sits between the LCD command engine, the pixel data writer and the PMOD TFT pins.

## Interface
- TURNAROUND, 2: idle cycles inserted after every release (0 allowed = none).
- HOLD_LIMIT, 4096: owner cycles allowed while the other side waits before overrun flag; 0 disables.
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- i_enable  in  1  low blocks new grants; current owner keeps the bus until release.
- i_cmd_req / i_data_req  in  1 each  bus request, held high for the whole transaction.
- o_cmd_gnt / o_data_gnt  out  1 each  registered grant; at most one high.
- i_cmd_cmd_mode, i_data_cmd_mode  in  1  requester cmd/data select (0 = command).
- i_cmd_data_out, i_data_data_out  in  8  requester write byte.
- i_cmd_write, i_data_write, i_cmd_read, i_data_read  in  1  requester strobes.
- i_cmd_data_out_en, i_data_data_out_en  in  1  requester output enable.
- o_cmd_mode, o_write, o_read, o_data_out_en  out  1  bus pins.
- o_data_out  out  8  bus write byte.
- i_data_in  in  8  bus read byte.
- o_rd_data  out  8  i_data_in registered, presented to both requesters.
- o_owner  out  2  0 none, 1 cmd, 2 data.
- o_overrun  out  1  sticky hold-limit violation flag.
- i_clear_overrun  in  1  clears o_overrun.

## Operation
- States: IDLE, OWN_CMD, OWN_DATA, TURNAROUND.
- IDLE: if i_enable and exactly one req high, grant it. If both high, grant the requester that was not the last owner (last_owner resets to data, so cmd wins first tie). Update last_owner on grant.
- OWN_x: while req_x high, stay. Requester drops req → TURNAROUND (or IDLE directly if TURNAROUND==0). The other requester is never granted from OWN_x.
- TURNAROUND: a counter loads TURNAROUND-1 on entry and decrements each cycle. At 0 → IDLE. Requests are ignored here.
- Pin register, every cycle: in OWN_x it loads requester x's cmd_mode/data_out/write/read/data_out_en. In every other state it loads idle values: cmd_mode=1, data_out=0, write=0, read=0, data_out_en=0. A requester's strobes are ignored when it has no grant.
- o_rd_data <= i_data_in every cycle.
- Hold counter: 16-bit, saturating, cleared on every grant. Increments in OWN_x while the other req is high. When HOLD_LIMIT!=0 and count reaches HOLD_LIMIT, o_overrun sets. The owner is not revoked.
- o_overrun clears on i_clear_overrun. If set and clear occur in the same cycle, set wins.
- i_enable dropping mid-ownership has no effect on the current owner. It only gates the IDLE grant decision.

## Timing
- Reset values: state IDLE, both gnt 0, o_owner 0, o_cmd_mode 1, o_data_out 0, o_write 0, o_read 0, o_data_out_en 0, o_rd_data 0, o_overrun 0, counters 0, last_owner data.
- Grant latency: req high at edge N in IDLE → gnt high after edge N+1. o_owner updates on the same edge.
- Pin latency: requester signals sampled at edge K while granted → on pins after edge K+1, i.e. 1 cycle.
- Release: req low sampled at edge M → gnt low after M+1. The next grant is possible no earlier than edge M+1+TURNAROUND+1.
- Requesters must have their strobes idle in the cycle they drop req. The arbiter still forwards that cycle's values.
- A request seen at edge N with i_enable low is not granted. If i_enable rises, the grant is decided at the first edge where i_enable is high in IDLE.
- Reset mid-ownership: next edge returns all reset values. Grant is dropped immediately and no turnaround is applied.

## Test plan
- Single cmd transaction: TURNAROUND=2, cmd req for 5 cycles writing 0x2C with cmd_mode=0 → gnt 1 cycle after req; pins show 0x2C/cmd_mode 0 one cycle after the requester drives them; 2 idle cycles after release; o_owner 1→0.
- Simultaneous requests from reset: both req high → cmd granted first. After cmd releases plus turnaround, data is granted. A repeat tie with last_owner=data → cmd.
- Isolation: while data owns, toggle i_cmd_write/i_cmd_data_out=0xFF → pins show only the data requester's values and o_cmd_gnt stays 0.
- Overrun: HOLD_LIMIT=8, data holds 20 cycles with cmd waiting → o_overrun rises at hold count 8, stays set, owner is not revoked. i_clear_overrun → 0.
- Enable gating: i_enable=0 with cmd req → no grant for 10 cycles. Raise i_enable → gnt after 1 edge. Drop i_enable during ownership → owner keeps the bus.
- Reset mid-frame: assert rst while OWN_DATA with o_write high → after 1 edge, all outputs at reset values.
